cacheline_arbiter: RTL and testbench

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

---
 rtl/cacheline_arbiter.sv | 116 +++++++++++
 tb/tb_cacheline_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// Two-client cache-line arbiter: I-cache and D-cache share one line adaptor.
// Round-robin on ties, no preemption, sticky busy-cycle watchdog.
module cacheline_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         icache_read_i,
  input  logic [31:0]  icache_addr_i,
  output logic [255:0] icache_line_o,
  output logic         icache_resp_o,
  input  logic         dcache_read_i,
  input  logic         dcache_write_i,
  input  logic [31:0]  dcache_addr_i,
  input  logic [255:0] dcache_line_i,
  output logic [255:0] dcache_line_o,
  output logic         dcache_resp_o,
  output logic         mem_read_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_line_o,
  input  logic [255:0] mem_line_i,
  input  logic         mem_resp_i,
  output logic [1:0]   grant_o,
  output logic         timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_BUSY = 2'b01,
    D_BUSY = 2'b10
  } state_e;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic        d_req;
  logic        pick_d;

  assign d_req  = dcache_read_i | dcache_write_i;
  // last_grant 1 means the D-cache won most recently, so a tie goes to the I-cache
  assign pick_d = d_req & (~icache_read_i | ~last_grant_q);

  assign icache_line_o = mem_line_i;
  assign dcache_line_o = mem_line_i;
  assign timeout_o     = timeout_q;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_d     = timeout_q;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = 32'd0;
    mem_line_o    = 256'd0;
    grant_o       = 2'b00;
    icache_resp_o = 1'b0;
    dcache_resp_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d      = D_BUSY;
          last_grant_d = 1'b1;
          wd_cnt_d     = 16'd0;
        end else if (icache_read_i) begin
          state_d      = I_BUSY;
          last_grant_d = 1'b0;
          wd_cnt_d     = 16'd0;
        end
      end
      I_BUSY: begin
        mem_read_o    = 1'b1;
        mem_addr_o    = icache_addr_i;
        grant_o       = 2'b01;
        icache_resp_o = mem_resp_i;
        if (mem_resp_i) state_d = IDLE;
      end
      D_BUSY: begin
        mem_write_o   = dcache_write_i;
        mem_read_o    = dcache_read_i & ~dcache_write_i;
        mem_addr_o    = dcache_addr_i;
        mem_line_o    = dcache_line_i;
        grant_o       = 2'b10;
        dcache_resp_o = mem_resp_i;
        if (mem_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog only observes; a stalled transaction keeps its grant
    if (state_q != IDLE) begin
      if (wd_cnt_q != 16'hFFFF) wd_cnt_d = wd_cnt_q + 16'd1;
      if (wd_cnt_d >= TIMEOUT_L) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      wd_cnt_q     <= 16'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: grants, round-robin, writeback, watchdog, reset.
module tb_cacheline_arbiter;

  logic         clk;
  logic         reset_n;
  logic         icache_read_i;
  logic [31:0]  icache_addr_i;
  logic [255:0] icache_line_o;
  logic         icache_resp_o;
  logic         dcache_read_i;
  logic         dcache_write_i;
  logic [31:0]  dcache_addr_i;
  logic [255:0] dcache_line_i;
  logic [255:0] dcache_line_o;
  logic         dcache_resp_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_line_o;
  logic [255:0] mem_line_i;
  logic         mem_resp_i;
  logic [1:0]   grant_o;
  logic         timeout_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  cacheline_arbiter #(.TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_read_i(icache_read_i), .icache_addr_i(icache_addr_i),
    .icache_line_o(icache_line_o), .icache_resp_o(icache_resp_o),
    .dcache_read_i(dcache_read_i), .dcache_write_i(dcache_write_i),
    .dcache_addr_i(dcache_addr_i), .dcache_line_i(dcache_line_i),
    .dcache_line_o(dcache_line_o), .dcache_resp_o(dcache_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_line_o(mem_line_o),
    .mem_line_i(mem_line_i), .mem_resp_i(mem_resp_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are checked 1ns later still.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    icache_read_i = 0; dcache_read_i = 0; dcache_write_i = 0; mem_resp_i = 0;
    tick();
    reset_n = 0;
    #3;
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    icache_read_i = 0; icache_addr_i = 0;
    dcache_read_i = 0; dcache_write_i = 0; dcache_addr_i = 0; dcache_line_i = 0;
    mem_line_i = 0; mem_resp_i = 0;
    #2;
    vec_cnt++;
    if (grant_o !== 2'b00) begin err_cnt++; $display("[TB] FAIL reset_grant: got %b expected 00", grant_o); end
    vec_cnt++;
    if ({mem_read_o, mem_write_o} !== 2'b00) begin err_cnt++; $display("[TB] FAIL reset_mem_req: got %b expected 00", {mem_read_o, mem_write_o}); end
    vec_cnt++;
    if ({icache_resp_o, dcache_resp_o, timeout_o} !== 3'b000) begin err_cnt++; $display("[TB] FAIL reset_flags: got %b expected 000", {icache_resp_o, dcache_resp_o, timeout_o}); end
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_icache_read();
    icache_read_i = 1; icache_addr_i = 32'h1000;
    #1;
    vec_cnt++;
    if (mem_read_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL icache_same_cycle: got %b expected 0", mem_read_o); end
    tick();
    #1;
    vec_cnt++;
    if ({mem_read_o, mem_write_o, grant_o} !== 4'b1001) begin err_cnt++; $display("[TB] FAIL icache_req: got %b expected 1001", {mem_read_o, mem_write_o, grant_o}); end
    vec_cnt++;
    if (mem_addr_o !== 32'h1000) begin err_cnt++; $display("[TB] FAIL icache_addr: got %h expected 00001000", mem_addr_o); end
    vec_cnt++;
    if (icache_resp_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL icache_early_resp: got %b expected 0", icache_resp_o); end
    mem_line_i = {8{32'hDEADBEEF}};
    mem_resp_i = 1;
    #1;
    vec_cnt++;
    if ({icache_resp_o, dcache_resp_o} !== 2'b10) begin err_cnt++; $display("[TB] FAIL icache_resp: got %b expected 10", {icache_resp_o, dcache_resp_o}); end
    vec_cnt++;
    if (icache_line_o !== {8{32'hDEADBEEF}}) begin err_cnt++; $display("[TB] FAIL icache_line: got %h expected %h", icache_line_o, {8{32'hDEADBEEF}}); end
    tick();
    mem_resp_i = 0; icache_read_i = 0;
    #1;
    vec_cnt++;
    if ({grant_o, mem_read_o} !== 3'b000) begin err_cnt++; $display("[TB] FAIL icache_done: got %b expected 000", {grant_o, mem_read_o}); end
    vec_cnt++;
    if (mem_addr_o !== 32'h0) begin err_cnt++; $display("[TB] FAIL idle_addr: got %h expected 00000000", mem_addr_o); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    icache_read_i = 1; icache_addr_i = 32'h3000;
    dcache_read_i = 1; dcache_addr_i = 32'h4000;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      vec_cnt++;
      if (grant_o !== exp_grant[i]) begin err_cnt++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", i, grant_o, exp_grant[i]); end
      vec_cnt++;
      if (mem_addr_o !== ((exp_grant[i] == 2'b10) ? 32'h4000 : 32'h3000)) begin err_cnt++; $display("[TB] FAIL rr_addr[%0d]: got %h", i, mem_addr_o); end
      vec_cnt++;
      if ({mem_read_o, mem_write_o} !== 2'b10) begin err_cnt++; $display("[TB] FAIL rr_mem_req[%0d]: got %b expected 10", i, {mem_read_o, mem_write_o}); end
      mem_resp_i = 1;
      #1;
      vec_cnt++;
      if ({dcache_resp_o, icache_resp_o} !== exp_grant[i]) begin err_cnt++; $display("[TB] FAIL rr_resp[%0d]: got %b expected %b", i, {dcache_resp_o, icache_resp_o}, exp_grant[i]); end
      tick();
      mem_resp_i = 0;
      #1;
      vec_cnt++;
      if (grant_o !== 2'b00) begin err_cnt++; $display("[TB] FAIL rr_idle_gap[%0d]: got %b expected 00", i, grant_o); end
    end
    icache_read_i = 0; dcache_read_i = 0;
    tick();
  endtask

  task automatic test_dcache_write();
    dcache_write_i = 1; dcache_addr_i = 32'h2040; dcache_line_i = {32{8'hA5}};
    tick();
    #1;
    vec_cnt++;
    if ({mem_write_o, mem_read_o, grant_o} !== 4'b1010) begin err_cnt++; $display("[TB] FAIL dwr_req: got %b expected 1010", {mem_write_o, mem_read_o, grant_o}); end
    vec_cnt++;
    if (mem_addr_o !== 32'h2040) begin err_cnt++; $display("[TB] FAIL dwr_addr: got %h expected 00002040", mem_addr_o); end
    vec_cnt++;
    if (mem_line_o !== {32{8'hA5}}) begin err_cnt++; $display("[TB] FAIL dwr_line: got %h", mem_line_o); end
    dcache_read_i = 1;
    #1;
    vec_cnt++;
    if ({mem_write_o, mem_read_o} !== 2'b10) begin err_cnt++; $display("[TB] FAIL dwr_write_wins: got %b expected 10", {mem_write_o, mem_read_o}); end
    mem_resp_i = 1;
    #1;
    vec_cnt++;
    if ({dcache_resp_o, icache_resp_o} !== 2'b10) begin err_cnt++; $display("[TB] FAIL dwr_resp: got %b expected 10", {dcache_resp_o, icache_resp_o}); end
    tick();
    mem_resp_i = 0; dcache_write_i = 0; dcache_read_i = 0;
    tick();
  endtask

  task automatic test_idle_resp();
    mem_resp_i = 1;
    #1;
    vec_cnt++;
    if ({icache_resp_o, dcache_resp_o} !== 2'b00) begin err_cnt++; $display("[TB] FAIL idle_resp: got %b expected 00", {icache_resp_o, dcache_resp_o}); end
    tick();
    mem_resp_i = 0;
    #1;
    vec_cnt++;
    if (grant_o !== 2'b00) begin err_cnt++; $display("[TB] FAIL idle_resp_state: got %b expected 00", grant_o); end
  endtask

  task automatic test_drop_request();
    icache_read_i = 1; icache_addr_i = 32'h5000;
    tick();
    icache_read_i = 0;
    tick();
    tick();
    vec_cnt++;
    if ({grant_o, mem_read_o} !== 3'b011) begin err_cnt++; $display("[TB] FAIL drop_hold: got %b expected 011", {grant_o, mem_read_o}); end
    mem_resp_i = 1;
    #1;
    vec_cnt++;
    if (icache_resp_o !== 1'b1) begin err_cnt++; $display("[TB] FAIL drop_resp: got %b expected 1", icache_resp_o); end
    tick();
    mem_resp_i = 0;
    tick();
  endtask

  task automatic test_timeout();
    dcache_read_i = 1; dcache_addr_i = 32'h6000;
    tick();
    for (int i = 0; i < 63; i++) tick();
    vec_cnt++;
    if (timeout_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL timeout_early: got %b expected 0", timeout_o); end
    tick();
    vec_cnt++;
    if ({timeout_o, grant_o} !== 3'b110) begin err_cnt++; $display("[TB] FAIL timeout_set: got %b expected 110", {timeout_o, grant_o}); end
    mem_resp_i = 1;
    #1;
    vec_cnt++;
    if (dcache_resp_o !== 1'b1) begin err_cnt++; $display("[TB] FAIL timeout_resp: got %b expected 1", dcache_resp_o); end
    tick();
    mem_resp_i = 0; dcache_read_i = 0;
    tick();
    tick();
    vec_cnt++;
    if (timeout_o !== 1'b1) begin err_cnt++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_o); end
    do_reset();
    vec_cnt++;
    if (timeout_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL timeout_clear: got %b expected 0", timeout_o); end
  endtask

  task automatic test_reset_mid_txn();
    dcache_write_i = 1; dcache_addr_i = 32'h7000;
    tick();
    vec_cnt++;
    if (mem_write_o !== 1'b1) begin err_cnt++; $display("[TB] FAIL midrst_busy: got %b expected 1", mem_write_o); end
    #2;
    reset_n = 0;
    #1;
    vec_cnt++;
    if ({mem_write_o, grant_o} !== 3'b000) begin err_cnt++; $display("[TB] FAIL midrst_async: got %b expected 000", {mem_write_o, grant_o}); end
    dcache_write_i = 0;
    tick();
    reset_n = 1;
    tick();
    mem_resp_i = 1;
    #1;
    vec_cnt++;
    if ({icache_resp_o, dcache_resp_o} !== 2'b00) begin err_cnt++; $display("[TB] FAIL midrst_stale_resp: got %b expected 00", {icache_resp_o, dcache_resp_o}); end
    tick();
    mem_resp_i = 0;
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_round_robin();
    test_dcache_write();
    test_idle_resp();
    test_drop_request();
    test_timeout();
    test_reset_mid_txn();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
